// File: rtl/store_demux4_if.sv
// Store-request and target-write bundle for store_demux4.
// slave is the demux side; master is the core/peripheral side driving it.
interface store_demux4_if #(
   parameter int unsigned W  = 32,
   parameter int unsigned AW = 32
);
   localparam int unsigned BW = W / 8;

   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_addr;
   logic [W-1:0]  req_data;
   logic [BW-1:0] req_be;

   logic [3:0]    t_valid;
   logic [3:0]    t_ready;
   logic [AW-1:0] t_addr;
   logic [W-1:0]  t_data;
   logic [BW-1:0] t_be;

   logic          resp_valid;
   logic          resp_err;
   logic          busy;

   modport slave (
      input  req_valid, req_addr, req_data, req_be, t_ready,
      output req_ready, t_valid, t_addr, t_data, t_be, resp_valid, resp_err, busy
   );

   modport master (
      output req_valid, req_addr, req_data, req_be, t_ready,
      input  req_ready, t_valid, t_addr, t_data, t_be, resp_valid, resp_err, busy
   );
endinterface

// File: rtl/store_demux4.sv
// Routes one store request to one of four targets selected by two address bits,
// waits (bounded) for the target to accept, then returns a one-cycle response.
module store_demux4 #(
   parameter int unsigned W       = 32,
   parameter int unsigned AW      = 32,
   parameter int unsigned SEL_LSB = 28,
   parameter logic [3:0]  TGT_EN  = 4'b1111,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic           clk,
   input  logic           rst_n,
   store_demux4_if.slave  bus
);
   localparam int unsigned BW = W / 8;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [1:0]    r_sel;
   logic [1:0]    w_sel_nxt;
   logic          r_err;
   logic          w_err_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_cap;

   logic [AW-1:0] r_addr;
   logic [W-1:0]  r_data;
   logic [BW-1:0] r_be;

   logic [1:0]    w_req_sel;
   logic          w_sel_rdy;
   logic          w_cnt_last;

   assign w_req_sel  = bus.req_addr[SEL_LSB +: 2];
   assign w_sel_rdy  = bus.t_ready[r_sel];
   assign w_cnt_last = (r_cnt == CW'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, select, error and wait-counter decisions
   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_err_nxt   = r_err;
      w_cnt_nxt   = r_cnt;
      w_cap       = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.req_valid) begin
               w_cap     = 1'b1;
               w_sel_nxt = w_req_sel;
               w_cnt_nxt = '0;
               if (TGT_EN[w_req_sel]) begin
                  w_state_nxt = SEND;
                  w_err_nxt   = 1'b0;
               end else begin
                  w_state_nxt = RESP;
                  w_err_nxt   = 1'b1;
               end
            end
         end
         SEND: begin
            // A handshake on the final allowed cycle still counts as success.
            if (w_sel_rdy) begin
               w_state_nxt = RESP;
               w_err_nxt   = 1'b0;
            end else if (w_cnt_last) begin
               w_state_nxt = RESP;
               w_err_nxt   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         RESP: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Transaction context registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel <= 2'd0;
         r_err <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_sel <= w_sel_nxt;
         r_err <= w_err_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

   // Captured payload, only updated on acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr <= '0;
         r_data <= '0;
         r_be   <= '0;
      end else if (w_cap) begin
         r_addr <= bus.req_addr;
         r_data <= bus.req_data;
         r_be   <= bus.req_be;
      end
   end

   // Outputs decode registered state only
   assign bus.req_ready  = (r_state == IDLE);
   assign bus.busy       = (r_state != IDLE);
   assign bus.t_valid    = (r_state == SEND) ? (4'b0001 << r_sel) : 4'b0000;
   assign bus.resp_valid = (r_state == RESP);
   assign bus.resp_err   = (r_state == RESP) && r_err;
   assign bus.t_addr     = r_addr;
   assign bus.t_data     = r_data;
   assign bus.t_be       = r_be;

   a_tvalid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(bus.t_valid));
   a_err_qualified: assert property (@(posedge clk) disable iff (!rst_n)
      bus.resp_err |-> bus.resp_valid);
   a_cnt_bounded: assert property (@(posedge clk) disable iff (!rst_n)
      32'(r_cnt) < TIMEOUT);
   a_payload_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (r_state != IDLE) |=> ($stable(r_addr) && $stable(r_data) && $stable(r_be)));
endmodule
